mem_port_arbiter: RTL and testbench

//  Shares the single-port 256x16 unified memory between two requesters:
//  - the instruction fetch unit (IF)
//  - the data/load-store unit (DU)

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory signal bundle for mem_port_arbiter
//
// Purpose: groups the IF read port, the DU read/write port, the unified memory
// port and the busy flag so the arbiter takes a single bus port.
// Ports (interface signals):
//    if_req/if_addr          IF read request and address
//    if_rdata/if_ack         IF registered read data and completion pulse
//    du_req/du_we/du_addr/du_wdata   DU request, direction, address, write data
//    du_rdata/du_ack         DU registered read data and completion pulse
//    mem_we/mem_addr/mem_wdata       unified memory write enable, address, data
//    mem_rdata               unified memory combinational read data
//    busy                    high while an access is granted
// Modports: slave = arbiter side, master = requesters plus memory side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;
   logic              du_req;
   logic              du_we;
   logic [ADDR_W-1:0] du_addr;
   logic [DATA_W-1:0] du_wdata;
   logic [DATA_W-1:0] du_rdata;
   logic              du_ack;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;

   modport slave (
      input  if_req, if_addr, du_req, du_we, du_addr, du_wdata, mem_rdata,
      output if_rdata, if_ack, du_rdata, du_ack, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output if_req, if_addr, du_req, du_we, du_addr, du_wdata, mem_rdata,
      input  if_rdata, if_ack, du_rdata, du_ack, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for the single-port unified memory
//
// Purpose: grants the instruction fetch unit (IF) and the load/store unit (DU)
// one memory access per two-cycle slot. A request seen in IDLE is latched,
// the memory is driven for one GRANT cycle, and a one-cycle ack carries the
// registered read data back to the requester.
// Ports:
//    clk_i   system clock, rising edge
//    rst_i   asynchronous active-high reset
//    bus     mem_port_arbiter_if.slave: IF port, DU port, memory port, busy
// Parameters:
//    ADDR_W     memory address width
//    DATA_W     memory word width
//    FIXED_PRI  0 = round-robin on ties, 1 = DU always wins ties
module mem_port_arbiter #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 16,
   parameter int FIXED_PRI = 0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   mem_port_arbiter_if.slave   bus
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'b001,
      ST_GRANT_IF = 3'b010,
      ST_GRANT_DU = 3'b100
   } state_t;

   state_t            state_q, state_d;
   logic              last_du_q, last_du_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic              if_ack_q, if_ack_d;
   logic [DATA_W-1:0] du_rdata_q, du_rdata_d;
   logic              du_ack_q, du_ack_d;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              busy;

   // A requester whose ack is high this cycle is still holding req from the
   // access just completed, so it is not a new request yet.
   logic if_elig, du_elig, pick_du;
   assign if_elig = bus.if_req && !if_ack_q;
   assign du_elig = bus.du_req && !du_ack_q;
   assign pick_du = du_elig && (!if_elig || (FIXED_PRI != 0) || !last_du_q);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         last_du_q  <= 1'b1;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         if_ack_q   <= 1'b0;
         du_rdata_q <= '0;
         du_ack_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_du_q  <= last_du_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         if_ack_q   <= if_ack_d;
         du_rdata_q <= du_rdata_d;
         du_ack_q   <= du_ack_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      last_du_d  = last_du_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      du_rdata_d = du_rdata_q;
      if_ack_d   = 1'b0;
      du_ack_d   = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      busy       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_du) begin
               state_d = ST_GRANT_DU;
               addr_d  = bus.du_addr;
               we_d    = bus.du_we;
               wdata_d = bus.du_wdata;
            end else if (if_elig) begin
               state_d = ST_GRANT_IF;
               addr_d  = bus.if_addr;
               we_d    = 1'b0;
               wdata_d = '0;
            end
         end
         ST_GRANT_IF: begin
            busy       = 1'b1;
            mem_addr   = addr_q;
            if_rdata_d = bus.mem_rdata;
            if_ack_d   = 1'b1;
            last_du_d  = 1'b0;
            state_d    = ST_IDLE;
         end
         ST_GRANT_DU: begin
            busy      = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_we    = we_q;
            if (!we_q) begin
               du_rdata_d = bus.mem_rdata;
            end
            du_ack_d  = 1'b1;
            last_du_d = 1'b1;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.if_rdata  = if_rdata_q;
   assign bus.if_ack    = if_ack_q;
   assign bus.du_rdata  = du_rdata_q;
   assign bus.du_ack    = du_ack_q;
   assign bus.mem_we    = mem_we;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = mem_wdata;
   assign bus.busy      = busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
   localparam int AW = 8;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRI(0)) u_rr (
      .clk_i(clk), .rst_i(rst), .bus(b0));
   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRI(1)) u_fp (
      .clk_i(clk), .rst_i(rst), .bus(b1));

   // stimulus, index 0 = round-robin DUT, 1 = fixed-priority DUT
   logic          if_req [2];
   logic [AW-1:0] if_addr [2];
   logic          du_req [2];
   logic          du_we [2];
   logic [AW-1:0] du_addr [2];
   logic [DW-1:0] du_wdata [2];

   assign b0.if_req = if_req[0];  assign b1.if_req = if_req[1];
   assign b0.if_addr = if_addr[0]; assign b1.if_addr = if_addr[1];
   assign b0.du_req = du_req[0];  assign b1.du_req = du_req[1];
   assign b0.du_we = du_we[0];    assign b1.du_we = du_we[1];
   assign b0.du_addr = du_addr[0]; assign b1.du_addr = du_addr[1];
   assign b0.du_wdata = du_wdata[0]; assign b1.du_wdata = du_wdata[1];

   logic [DW-1:0] o_if_rdata [2], o_du_rdata [2], o_mem_wdata [2];
   logic [AW-1:0] o_mem_addr [2];
   logic          o_if_ack [2], o_du_ack [2], o_mem_we [2], o_busy [2];

   assign o_if_rdata[0] = b0.if_rdata;   assign o_if_rdata[1] = b1.if_rdata;
   assign o_du_rdata[0] = b0.du_rdata;   assign o_du_rdata[1] = b1.du_rdata;
   assign o_mem_wdata[0] = b0.mem_wdata; assign o_mem_wdata[1] = b1.mem_wdata;
   assign o_mem_addr[0] = b0.mem_addr;   assign o_mem_addr[1] = b1.mem_addr;
   assign o_if_ack[0] = b0.if_ack;       assign o_if_ack[1] = b1.if_ack;
   assign o_du_ack[0] = b0.du_ack;       assign o_du_ack[1] = b1.du_ack;
   assign o_mem_we[0] = b0.mem_we;       assign o_mem_we[1] = b1.mem_we;
   assign o_busy[0] = b0.busy;           assign o_busy[1] = b1.busy;

   // the memories the two DUTs actually talk to
   logic [DW-1:0] env_mem0 [256];
   logic [DW-1:0] env_mem1 [256];
   assign b0.mem_rdata = env_mem0[b0.mem_addr];
   assign b1.mem_rdata = env_mem1[b1.mem_addr];
   always @(posedge clk) if (b0.mem_we === 1'b1) env_mem0[b0.mem_addr] <= b0.mem_wdata;
   always @(posedge clk) if (b1.mem_we === 1'b1) env_mem1[b1.mem_addr] <= b1.mem_wdata;

   // reference model: one access record per slot, plus the pending ack
   logic [DW-1:0] ref_mem [2][256];
   bit            g_valid [2], g_du [2], g_we [2], last_du [2];
   logic [AW-1:0] g_addr [2];
   logic [DW-1:0] g_data [2];
   int            ack_who [2];   // 0 none, 1 IF, 2 DU
   logic [DW-1:0] e_if_rdata [2], e_du_rdata [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         g_valid[d] = 1'b0; g_du[d] = 1'b0; g_we[d] = 1'b0; last_du[d] = 1'b1;
         g_addr[d] = '0; g_data[d] = '0; ack_who[d] = 0;
         e_if_rdata[d] = '0; e_du_rdata[d] = '0;
      end
   endtask

   task automatic model_step(input int d);
      int prev_ack;
      bit ie, de, take_du;
      prev_ack = ack_who[d];
      ack_who[d] = 0;
      if (g_valid[d]) begin
         if (g_du[d]) begin
            if (g_we[d]) ref_mem[d][g_addr[d]] = g_data[d];
            else e_du_rdata[d] = ref_mem[d][g_addr[d]];
            ack_who[d] = 2;
            last_du[d] = 1'b1;
         end else begin
            e_if_rdata[d] = ref_mem[d][g_addr[d]];
            ack_who[d] = 1;
            last_du[d] = 1'b0;
         end
         g_valid[d] = 1'b0;
      end else begin
         ie = if_req[d] && (prev_ack != 1);
         de = du_req[d] && (prev_ack != 2);
         if (ie && de) take_du = (d == 1) ? 1'b1 : !last_du[d];
         else take_du = de;
         if (ie || de) begin
            g_valid[d] = 1'b1;
            g_du[d] = take_du;
            g_addr[d] = take_du ? du_addr[d] : if_addr[d];
            g_we[d] = take_du && du_we[d];
            g_data[d] = take_du ? du_wdata[d] : '0;
         end
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else for (int d = 0; d < 2; d++) model_step(d);
   end

   // compare process
   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d busy", d), 32'(o_busy[d]), 32'(g_valid[d]));
            check($sformatf("d%0d mem_we", d), 32'(o_mem_we[d]), 32'(g_valid[d] && g_du[d] && g_we[d]));
            check($sformatf("d%0d mem_addr", d), 32'(o_mem_addr[d]), g_valid[d] ? 32'(g_addr[d]) : 32'd0);
            check($sformatf("d%0d mem_wdata", d), 32'(o_mem_wdata[d]), (g_valid[d] && g_du[d]) ? 32'(g_data[d]) : 32'd0);
            check($sformatf("d%0d if_ack", d), 32'(o_if_ack[d]), 32'(ack_who[d] == 1));
            check($sformatf("d%0d du_ack", d), 32'(o_du_ack[d]), 32'(ack_who[d] == 2));
            check($sformatf("d%0d if_rdata", d), 32'(o_if_rdata[d]), 32'(e_if_rdata[d]));
            check($sformatf("d%0d du_rdata", d), 32'(o_du_rdata[d]), 32'(e_du_rdata[d]));
         end
      end
   end

   function automatic logic [AW-1:0] rand_addr();
      logic [AW-1:0] a;
      if ($urandom_range(0, 5) == 0) a = 8'hFF;
      else a = AW'($urandom_range(0, 15));
      return a;
   endfunction

   int            wait_if [2], wait_du [2];
   logic [DW-1:0] keep;

   initial begin
      for (int d = 0; d < 2; d++) begin
         if_req[d] = 1'b0; if_addr[d] = '0; du_req[d] = 1'b0; du_we[d] = 1'b0;
         du_addr[d] = '0; du_wdata[d] = '0; wait_if[d] = 0; wait_du[d] = 0;
      end
      for (int i = 0; i < 256; i++) begin
         keep = DW'($urandom);
         env_mem0[i] = keep; ref_mem[0][i] = keep;
         keep = DW'($urandom);
         env_mem1[i] = keep; ref_mem[1][i] = keep;
      end
      env_mem0[0] = 16'h3406; ref_mem[0][0] = 16'h3406;

      // 1: reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      check("reset busy", 32'(o_busy[0]), 32'd0);
      check("reset if_ack", 32'(o_if_ack[0]), 32'd0);
      check("reset mem_addr", 32'(o_mem_addr[0]), 32'd0);
      check("reset du_rdata", 32'(o_du_rdata[1]), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle busy", 32'(o_busy[0]), 32'd0);

      // 2: IF read of address 0
      @(posedge clk); #1 if_req[0] = 1'b1; if_addr[0] = 8'd0;
      @(negedge clk);
      @(negedge clk);
      check("t2 busy", 32'(o_busy[0]), 32'd1);
      check("t2 early ack", 32'(o_if_ack[0]), 32'd0);
      @(negedge clk);
      check("t2 ack", 32'(o_if_ack[0]), 32'd1);
      check("t2 rdata", 32'(o_if_rdata[0]), 32'h3406);
      #1 if_req[0] = 1'b0;
      @(negedge clk);
      check("t2 one pulse", 32'(o_if_ack[0]), 32'd0);

      // 4: DU write 63 then read 63 with req held
      @(posedge clk); #1 du_req[0] = 1'b1; du_we[0] = 1'b1; du_addr[0] = 8'd63; du_wdata[0] = 16'h00FF;
      @(negedge clk);
      @(negedge clk);
      check("t4 mem_we", 32'(o_mem_we[0]), 32'd1);
      check("t4 mem_addr", 32'(o_mem_addr[0]), 32'd63);
      check("t4 mem_wdata", 32'(o_mem_wdata[0]), 32'h00FF);
      @(negedge clk);
      check("t4 wr ack", 32'(o_du_ack[0]), 32'd1);
      check("t4 we low", 32'(o_mem_we[0]), 32'd0);
      #1 du_we[0] = 1'b0; du_wdata[0] = 16'h0000;
      @(negedge clk);
      check("t4 ack filter", 32'(o_busy[0]), 32'd0);
      @(negedge clk);
      check("t4 rd grant", 32'(o_busy[0]), 32'd1);
      check("t4 rd we", 32'(o_mem_we[0]), 32'd0);
      @(negedge clk);
      check("t4 rd ack", 32'(o_du_ack[0]), 32'd1);
      check("t4 rd data", 32'(o_du_rdata[0]), 32'h00FF);
      #1 du_req[0] = 1'b0;

      // 3: both held, alternate IF, DU, IF, DU two cycles apart
      @(posedge clk); #1 if_req[0] = 1'b1; if_addr[0] = 8'd5;
      du_req[0] = 1'b1; du_we[0] = 1'b0; du_addr[0] = 8'd63;
      @(negedge clk);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check($sformatf("t3 if_ack k%0d", k), 32'(o_if_ack[0]), 32'(k == 2 || k == 6));
         check($sformatf("t3 du_ack k%0d", k), 32'(o_du_ack[0]), 32'(k == 4 || k == 8));
      end
      #1 if_req[0] = 1'b0; du_req[0] = 1'b0;

      // 5: reset during a DU write grant
      @(posedge clk); #1 du_req[0] = 1'b1; du_we[0] = 1'b1; du_addr[0] = 8'd10; du_wdata[0] = 16'hBEEF;
      keep = env_mem0[10];
      @(negedge clk);
      @(negedge clk);
      check("t5 mem_we", 32'(o_mem_we[0]), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("t5 we drop", 32'(o_mem_we[0]), 32'd0);
      check("t5 busy drop", 32'(o_busy[0]), 32'd0);
      du_req[0] = 1'b0; du_we[0] = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("t5 no ack", 32'(o_du_ack[0]), 32'd0);
         check("t5 idle", 32'(o_busy[0]), 32'd0);
      end
      check("t5 mem kept", 32'(env_mem0[10]), 32'(keep));

      // 6: fixed priority, DU wins the tie, IF follows
      @(posedge clk); #1 if_req[1] = 1'b1; if_addr[1] = 8'd7;
      du_req[1] = 1'b1; du_we[1] = 1'b0; du_addr[1] = 8'd8;
      @(negedge clk);
      @(negedge clk);
      check("t6 du first", 32'(o_mem_addr[1]), 32'd8);
      @(negedge clk);
      check("t6 du ack", 32'(o_du_ack[1]), 32'd1);
      check("t6 no if ack", 32'(o_if_ack[1]), 32'd0);
      #1 du_req[1] = 1'b0;
      @(negedge clk);
      check("t6 if grant", 32'(o_mem_addr[1]), 32'd7);
      @(negedge clk);
      check("t6 if ack", 32'(o_if_ack[1]), 32'd1);
      #1 if_req[1] = 1'b0;

      // randomized traffic on both DUTs
      for (int c = 0; c < 600; c++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++) begin
            if (if_req[d]) begin
               if (o_if_ack[d]) begin
                  wait_if[d] = 0;
                  if ($urandom_range(0, 1) == 0) if_req[d] = 1'b0;
                  else if_addr[d] = rand_addr();
               end else if (++wait_if[d] > 12) begin
                  checks++; errors++;
                  $display("FAIL d%0d if timeout: waited %0d cycles, limit 12", d, wait_if[d]);
                  if_req[d] = 1'b0; wait_if[d] = 0;
               end
            end else if ($urandom_range(0, 99) < 40) begin
               if_req[d] = 1'b1; if_addr[d] = rand_addr(); wait_if[d] = 0;
            end
            if (du_req[d]) begin
               if (o_du_ack[d]) begin
                  wait_du[d] = 0;
                  if ($urandom_range(0, 1) == 0) du_req[d] = 1'b0;
                  else begin
                     du_we[d] = 1'($urandom_range(0, 1)); du_addr[d] = rand_addr(); du_wdata[d] = DW'($urandom);
                  end
               end else if (++wait_du[d] > 12) begin
                  checks++; errors++;
                  $display("FAIL d%0d du timeout: waited %0d cycles, limit 12", d, wait_du[d]);
                  du_req[d] = 1'b0; wait_du[d] = 0;
               end
            end else if ($urandom_range(0, 99) < 40) begin
               du_req[d] = 1'b1; du_we[d] = 1'($urandom_range(0, 1));
               du_addr[d] = rand_addr(); du_wdata[d] = DW'($urandom); wait_du[d] = 0;
            end
         end
      end
      for (int d = 0; d < 2; d++) begin
         if_req[d] = 1'b0; du_req[d] = 1'b0;
      end
      repeat (4) @(negedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
